// File: rtl/game2048_pkg.sv
// ==========================================================================
// game2048_pkg : shared types, directions, FSM states and tile helpers. Rev 1.0
// ==========================================================================
`default_nettype none

package game2048_pkg;

  localparam int TILE_W  = 4;
  localparam int WIN_EXP = 11;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  typedef logic [TILE_W-1:0]    tile_t;
  typedef logic [4*TILE_W-1:0]  line_t;
  typedef logic [16*TILE_W-1:0] board_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ISSUE  = 3'd1,
    WAIT   = 3'd2,
    COMMIT = 3'd3,
    SPAWN  = 3'd4,
    CHECK  = 3'd5,
    WIN    = 3'd6,
    LOSE   = 3'd7
  } state_e;

  function automatic tile_t get_tile(input board_t b, input logic [3:0] idx);
    return b[int'(idx)*TILE_W +: TILE_W];
  endfunction

  function automatic board_t set_tile(input board_t b, input logic [3:0] idx, input tile_t t);
    board_t r;
    r = b;
    r[int'(idx)*TILE_W +: TILE_W] = t;
    return r;
  endfunction

  // Element i of a line is the tile i steps away from the wall tiles slide toward.
  function automatic logic [3:0] line_index(input logic [1:0] dir, input logic [1:0] line,
                                            input logic [1:0] i);
    logic [1:0] row;
    logic [1:0] col;
    case (dir)
      DIR_UP:   begin row = i;         col = line;      end
      DIR_DOWN: begin row = 2'd3 - i;  col = line;      end
      DIR_LEFT: begin row = line;      col = i;         end
      default:  begin row = line;      col = 2'd3 - i;  end
    endcase
    return {row, col};
  endfunction

endpackage

`default_nettype wire

// File: rtl/move_sequencer_if.sv
// ==========================================================================
// move_sequencer_if : line-merge request/response handshake bundle. Rev 1.0
// ==========================================================================
`default_nettype none

interface move_sequencer_if;

  logic                  line_req_valid;
  game2048_pkg::line_t   line_req_data;
  logic                  line_req_ready;
  logic                  line_rsp_valid;
  game2048_pkg::line_t   line_rsp_data;
  logic [15:0]           line_rsp_score;

  modport master (
    output line_req_valid, line_req_data,
    input  line_req_ready, line_rsp_valid, line_rsp_data, line_rsp_score
  );

  modport slave (
    input  line_req_valid, line_req_data,
    output line_req_ready, line_rsp_valid, line_rsp_data, line_rsp_score
  );

endinterface

`default_nettype wire

// File: rtl/board_status_check.sv
// ==========================================================================
// board_status_check : combinational win / no-moves-left detection. Rev 1.0
// ==========================================================================
`default_nettype none

module board_status_check
  import game2048_pkg::*;
#(
  parameter int WIN_EXP = game2048_pkg::WIN_EXP
) (
  input  board_t board_i,
  output logic   win_o,
  output logic   lose_o
);

  logic  any_win;
  logic  any_empty;
  logic  any_pair;
  tile_t t;

  always_comb begin
    any_win   = 1'b0;
    any_empty = 1'b0;
    any_pair  = 1'b0;
    t         = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        t = get_tile(board_i, 4'(r*4 + c));
        if (int'(t) >= WIN_EXP) any_win = 1'b1;
        if (t == '0) any_empty = 1'b1;
        if ((c < 3) && (t == get_tile(board_i, 4'(r*4 + c + 1)))) any_pair = 1'b1;
        if ((r < 3) && (t == get_tile(board_i, 4'((r+1)*4 + c)))) any_pair = 1'b1;
      end
    end
  end

  assign win_o  = any_win;
  assign lose_o = !any_empty && !any_pair;

endmodule

`default_nettype wire

// File: rtl/move_sequencer.sv
// ==========================================================================
// move_sequencer : streams one 2048 move through the line-merge unit. Rev 1.0
// ==========================================================================
`default_nettype none

module move_sequencer
  import game2048_pkg::*;
#(
  parameter int SCORE_W = 20,
  parameter int WIN_EXP = game2048_pkg::WIN_EXP
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                dir_valid_i,
  input  logic [1:0]          dir_i,
  output logic                dir_ready_o,
  input  board_t              board_i,
  move_sequencer_if.master    line_if,
  output logic                board_we_o,
  output board_t              board_wdata_o,
  output logic                spawn_req_o,
  input  logic                spawn_ack_i,
  output logic [SCORE_W-1:0]  score_o,
  output logic                moved_o,
  output logic                busy_o,
  output logic                win_o,
  output logic                lose_o
);

  state_e             state_q;
  logic [1:0]         dir_q;
  logic [1:0]         line_q;
  board_t             work_q;
  logic               changed_q;
  logic [SCORE_W-1:0] score_q;
  logic               dir_ready_q;
  logic               req_valid_q;
  logic               board_we_q;
  logic               spawn_req_q;
  logic               moved_q;
  logic               busy_q;
  logic               win_q;
  logic               lose_q;

  line_t              req_line;
  board_t             work_d;
  logic               line_diff;
  logic [SCORE_W:0]   score_sum;
  logic [SCORE_W-1:0] score_d;
  logic               status_win;
  logic               status_lose;

  board_status_check #(.WIN_EXP(WIN_EXP)) u_status (
    .board_i (board_i),
    .win_o   (status_win),
    .lose_o  (status_lose)
  );

  // Gather the current line and scatter the merged line back via the same mapping.
  always_comb begin
    req_line = '0;
    work_d   = work_q;
    for (int i = 0; i < 4; i++) begin
      req_line[i*TILE_W +: TILE_W] = get_tile(work_q, line_index(dir_q, line_q, 2'(i)));
      work_d = set_tile(work_d, line_index(dir_q, line_q, 2'(i)),
                        line_if.line_rsp_data[i*TILE_W +: TILE_W]);
    end
    line_diff = (line_if.line_rsp_data != req_line);
    score_sum = {1'b0, score_q} + {{(SCORE_W-15){1'b0}}, line_if.line_rsp_score};
    score_d   = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      dir_q       <= '0;
      line_q      <= '0;
      work_q      <= '0;
      changed_q   <= 1'b0;
      score_q     <= '0;
      dir_ready_q <= 1'b1;
      req_valid_q <= 1'b0;
      board_we_q  <= 1'b0;
      spawn_req_q <= 1'b0;
      moved_q     <= 1'b0;
      busy_q      <= 1'b0;
      win_q       <= 1'b0;
      lose_q      <= 1'b0;
    end else begin
      board_we_q <= 1'b0;
      moved_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (dir_valid_i) begin
            dir_q       <= dir_i;
            work_q      <= board_i;
            line_q      <= '0;
            changed_q   <= 1'b0;
            dir_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            req_valid_q <= 1'b1;
            state_q     <= ISSUE;
          end
        end
        ISSUE: begin
          if (line_if.line_req_ready) begin
            req_valid_q <= 1'b0;
            state_q     <= WAIT;
          end
        end
        WAIT: begin
          if (line_if.line_rsp_valid) begin
            work_q    <= work_d;
            changed_q <= changed_q | line_diff;
            score_q   <= score_d;
            if (line_q == 2'd3) begin
              board_we_q <= 1'b1;
              moved_q    <= changed_q | line_diff;
              state_q    <= COMMIT;
            end else begin
              line_q      <= line_q + 2'd1;
              req_valid_q <= 1'b1;
              state_q     <= ISSUE;
            end
          end
        end
        COMMIT: begin
          if (changed_q) begin
            spawn_req_q <= 1'b1;
            state_q     <= SPAWN;
          end else begin
            state_q <= CHECK;
          end
        end
        SPAWN: begin
          if (spawn_ack_i) begin
            spawn_req_q <= 1'b0;
            state_q     <= CHECK;
          end
        end
        CHECK: begin
          busy_q <= 1'b0;
          if (status_win) begin
            win_q   <= 1'b1;
            state_q <= WIN;
          end else if (status_lose) begin
            lose_q  <= 1'b1;
            state_q <= LOSE;
          end else begin
            dir_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= state_q;
        end
      endcase
    end
  end

  assign line_if.line_req_valid = req_valid_q;
  assign line_if.line_req_data  = req_line;
  assign dir_ready_o            = dir_ready_q;
  assign board_we_o             = board_we_q;
  assign board_wdata_o          = work_q;
  assign spawn_req_o            = spawn_req_q;
  assign score_o                = score_q;
  assign moved_o                = moved_q;
  assign busy_o                 = busy_q;
  assign win_o                  = win_q;
  assign lose_o                 = lose_q;

endmodule

`default_nettype wire
